// File: rtl/lsu_wb_if.sv
// Data-memory bus between the load/store stage (master) and a variable-latency memory (slave).
interface lsu_wb_if #(
    parameter int ADDR_W = 12
);
    logic              mReq;
    logic              mWe;
    logic [ADDR_W-3:0] mAddr;
    logic [3:0]        mBe;
    logic [31:0]       mWData;
    logic              mGnt;
    logic              mRValid;
    logic [31:0]       mRData;

    modport master (
        output mReq, mWe, mAddr, mBe, mWData,
        input  mGnt, mRValid, mRData
    );

    modport slave (
        input  mReq, mWe, mAddr, mBe, mWData,
        output mGnt, mRValid, mRData
    );
endinterface

// File: rtl/lsu_wb.sv
// Load/store + writeback stage: one instruction in flight, byte-lane steering,
// load extension, misalign/illegal-size checks and a request timeout.
module lsu_wb_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] din,
    output logic        be,
    output logic [7:0]  wbyte
);
    always_comb begin
        be    = 1'b1;
        wbyte = din[8*LANE +: 8];
        case (size)
            2'b00: begin
                be    = (off == 2'(LANE));
                wbyte = din[7:0];
            end
            2'b01: begin
                be    = (off[1] == 1'(LANE / 2));
                wbyte = din[8*(LANE % 2) +: 8];
            end
            default: ;
        endcase
    end
endmodule

module lsu_wb #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inValid,
    output logic        inReady,
    input  logic [1:0]  wbCtrl,
    input  logic        memRD,
    input  logic        memWR,
    input  logic [2:0]  memCtrl,
    input  logic [31:0] pcN,
    input  logic [31:0] aluOut,
    input  logic [31:0] dataIn,
    input  logic [4:0]  rdIn,
    lsu_wb_if.master    mem,
    output logic        wbValid,
    output logic [4:0]  wbRd,
    output logic [31:0] wbOut,
    output logic        stall,
    output logic        exc,
    output logic [1:0]  excCause
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       cap_wbctrl;
    logic [2:0]       cap_ctrl;
    logic             cap_st;
    logic [31:0]      cap_pc, cap_alu;
    logic [4:0]       cap_rd;

    logic [3:0]      lane_be;
    logic [3:0][7:0] lane_wd;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        lsu_wb_lane #(.LANE(i)) u_lane (
            .size  (memCtrl[1:0]),
            .off   (aluOut[1:0]),
            .din   (dataIn),
            .be    (lane_be[i]),
            .wbyte (lane_wd[i])
        );
    end

    function automatic logic [31:0] ld_ext(input logic [2:0] ctrl, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = d >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? d[31:16] : d[15:0];
        case (ctrl)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] wb_sel(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic [31:0] ld);
        case (sel)
            2'b00:   return pc;
            2'b01:   return alu;
            2'b10:   return ld;
            default: return 32'h0;
        endcase
    endfunction

    logic accept, is_mem, illegal, misal, fault, busy, complete, tmo;

    assign inReady = (state == IDLE);
    assign stall   = inValid && !inReady;
    assign wbValid = (state == RESP);
    assign accept  = inValid && inReady;
    assign is_mem  = memRD || memWR;
    // BU/HU only exist as load encodings.
    assign illegal = (memCtrl == 3'b011) || (memCtrl[2:1] == 2'b11) || (memWR && memCtrl[2]);
    assign misal   = ((memCtrl[1:0] == 2'b01) && aluOut[0]) ||
                     ((memCtrl[1:0] == 2'b10) && (aluOut[1:0] != 2'b00));
    assign fault    = is_mem && (illegal || misal);
    assign busy     = (state == REQ) || (state == WAIT);
    assign complete = ((state == REQ) && mem.mGnt && (cap_st || mem.mRValid)) ||
                      ((state == WAIT) && mem.mRValid);
    assign tmo      = busy && !complete && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !fault) state_nxt = is_mem ? REQ : RESP;
            REQ: begin
                if (complete)      state_nxt = RESP;
                else if (tmo)      state_nxt = IDLE;
                else if (mem.mGnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (complete) state_nxt = RESP;
                else if (tmo) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem.mReq   <= 1'b0;
            mem.mWe    <= 1'b0;
            mem.mAddr  <= '0;
            mem.mBe    <= 4'h0;
            mem.mWData <= 32'h0;
            wbOut      <= 32'h0;
            wbRd       <= 5'h0;
            exc        <= 1'b0;
            excCause   <= 2'b00;
            cnt        <= '0;
            cap_wbctrl <= 2'b00;
            cap_ctrl   <= 3'b000;
            cap_st     <= 1'b0;
            cap_pc     <= 32'h0;
            cap_alu    <= 32'h0;
            cap_rd     <= 5'h0;
        end else begin
            exc <= 1'b0;
            if (accept) begin
                cap_wbctrl <= wbCtrl;
                cap_ctrl   <= memCtrl;
                cap_st     <= memWR;
                cap_pc     <= pcN;
                cap_alu    <= aluOut;
                cap_rd     <= rdIn;
                if (fault) begin
                    exc      <= 1'b1;
                    excCause <= illegal ? 2'b00 : (memWR ? 2'b10 : 2'b01);
                end else if (is_mem) begin
                    mem.mReq   <= 1'b1;
                    mem.mWe    <= memWR;
                    mem.mAddr  <= aluOut[ADDR_W-1:2];
                    mem.mBe    <= lane_be;
                    mem.mWData <= lane_wd;
                    cnt        <= '0;
                end else begin
                    wbOut <= wb_sel(wbCtrl, pcN, aluOut, 32'h0);
                    wbRd  <= rdIn;
                end
            end
            if (busy) begin
                cnt <= cnt + 1'b1;
                if ((state == REQ) && mem.mGnt) mem.mReq <= 1'b0;
                if (tmo) begin
                    mem.mReq <= 1'b0;
                    exc      <= 1'b1;
                    excCause <= 2'b11;
                end
                if (complete) begin
                    wbOut <= wb_sel(cap_wbctrl, cap_pc, cap_alu,
                                    cap_st ? 32'h0 : ld_ext(cap_ctrl, cap_alu[1:0], mem.mRData));
                    wbRd  <= cap_rd;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: vector table, hand-written latency/timeout/reset
// sequences, and randomized transactions against a transaction-level model.
module tb_lsu_wb;
    localparam int AW = 12;
    localparam int T  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0, memRD = 1'b0, memWR = 1'b0;
    logic [1:0]  wbCtrl = 2'b00;
    logic [2:0]  memCtrl = 3'b000;
    logic [31:0] pcN = 32'h0, aluOut = 32'h0, dataIn = 32'h0;
    logic [4:0]  rdIn = 5'h0;
    logic        inReady, wbValid, stall, exc;
    logic [4:0]  wbRd;
    logic [31:0] wbOut;
    logic [1:0]  excCause;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    lsu_wb_if #(.ADDR_W(AW)) mem ();

    lsu_wb #(.ADDR_W(AW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .wbCtrl(wbCtrl),
        .memRD(memRD), .memWR(memWR), .memCtrl(memCtrl), .pcN(pcN), .aluOut(aluOut),
        .dataIn(dataIn), .rdIn(rdIn), .mem(mem), .wbValid(wbValid), .wbRd(wbRd),
        .wbOut(wbOut), .stall(stall), .exc(exc), .excCause(excCause)
    );

    typedef struct {
        logic [1:0]  wc;
        logic        rd, wr;
        logic [2:0]  ctl;
        logic [31:0] pc, alu, din, rdata;
        logic        ex;
        logic [1:0]  cause;
        logic [3:0]  be;
        logic [31:0] wd, wbo;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wc, input logic rd, input logic wr, input logic [2:0] ctl,
                         input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] din,
                         input logic [4:0] rdi);
        inValid = 1'b1; wbCtrl = wc; memRD = rd; memWR = wr; memCtrl = ctl;
        pcN = pc; aluOut = alu; dataIn = din; rdIn = rdi;
    endtask

    // Reference rules, written from the size/offset definitions.
    function automatic logic [31:0] m_load(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        case (ctl[1:0])
            2'd0: begin
                v = (d >> (8 * int'(a[1:0]))) & 32'hFF;
                if (!ctl[2] && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = (d >> (16 * int'(a[1]))) & 32'hFFFF;
                if (!ctl[2] && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] ctl, input logic [31:0] a);
        if (ctl[1:0] == 2'd0) return 4'(1 << int'(a[1:0]));
        if (ctl[1:0] == 2'd1) return 4'(3 << (2 * int'(a[1])));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] ctl, input logic [31:0] d);
        if (ctl[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (ctl[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic load_latency(input logic [2:0] ctl, input logic [31:0] exp);
        drive(2'b10, 1'b1, 1'b0, ctl, 32'h0, 32'h002, 32'h0, 5'd7);
        step(); inValid = 1'b0;
        chk("lat mReq c1", 32'(mem.mReq), 32'd1);
        mem.mGnt = 1'b1;
        step(); mem.mGnt = 1'b0;
        chk("lat mReq c2", 32'(mem.mReq), 32'd0);
        chk("lat wbValid c2", 32'(wbValid), 32'd0);
        step();
        chk("lat wbValid c3", 32'(wbValid), 32'd0);
        step(); mem.mRValid = 1'b1; mem.mRData = 32'h8001_0000;
        chk("lat wbValid c4", 32'(wbValid), 32'd0);
        step(); mem.mRValid = 1'b0;
        chk("lat wbValid c5", 32'(wbValid), 32'd1);
        chk("lat wbOut", wbOut, exp);
        chk("lat wbRd", 32'(wbRd), 32'd7);
        step();
        chk("lat wbValid c6", 32'(wbValid), 32'd0);
        chk("lat wbOut hold", wbOut, exp);
    endtask

    task automatic run_random(input int n);
        logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [1:0]  wc, rw;
        logic [2:0]  ctl;
        logic [31:0] pc, alu, din, rdata, ev;
        logic [4:0]  rdi;
        logic        ismem, st, ill, mis, legal_mem, skipv;
        int g, r, comp, wbc, excc, mreq_end, last;
        logic [1:0]  ecause;
        for (int k = 0; k < n; k++) begin
            wc = 2'($urandom); rw = 2'($urandom); ctl = 3'($urandom);
            if ($urandom_range(0, 3) != 0) ctl = legal[$urandom_range(0, 4)];
            alu = $urandom; if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            pc = $urandom; din = $urandom; rdata = $urandom; rdi = 5'($urandom);
            g = $urandom_range(1, 6); r = g + $urandom_range(0, 3);
            ismem = rw[0] | rw[1]; st = rw[1];
            ill = (ctl == 3'd3) || (ctl >= 3'd6) || (st && ctl >= 3'd4);
            mis = !ill && ((ctl[1:0] == 2'd1 && alu[0]) || (ctl[1:0] == 2'd2 && alu[1:0] != 2'd0));
            legal_mem = ismem && !ill && !mis;
            wbc = -1; excc = -1; mreq_end = 0; ecause = 2'b00; ev = 32'h0; skipv = 1'b0;
            if (!ismem) begin
                wbc = 1;
            end else if (ill || mis) begin
                excc = 1; ecause = ill ? 2'b00 : (st ? 2'b10 : 2'b01);
            end else begin
                comp = st ? g : r;
                mreq_end = (g < T) ? g : T;
                if (comp <= T) wbc = comp + 1;
                else begin excc = T + 1; ecause = 2'b11; end
            end
            case (wc)
                2'b00: ev = pc;
                2'b01: ev = alu;
                2'b10: if (legal_mem && !st) ev = m_load(ctl, alu, rdata); else skipv = 1'b1;
                default: ev = 32'h0;
            endcase
            last = (wbc > 0) ? wbc : excc;
            chk($sformatf("rnd%0d inReady", k), 32'(inReady), 32'd1);
            drive(wc, rw[0], rw[1], ctl, pc, alu, din, rdi);
            step(); inValid = 1'b0;
            for (int c = 1; c <= last; c++) begin
                mem.mGnt = (c == g); mem.mRValid = (c == r); mem.mRData = rdata;
                chk($sformatf("rnd%0d c%0d mReq", k, c), 32'(mem.mReq), 32'(legal_mem && c <= mreq_end));
                chk($sformatf("rnd%0d c%0d wbValid", k, c), 32'(wbValid), 32'(c == wbc));
                chk($sformatf("rnd%0d c%0d exc", k, c), 32'(exc), 32'(c == excc));
                if (c == 1 && legal_mem) begin
                    chk($sformatf("rnd%0d mBe", k), 32'(mem.mBe), 32'(m_be(ctl, alu)));
                    chk($sformatf("rnd%0d mAddr", k), 32'(mem.mAddr), 32'(alu[AW-1:2]));
                    chk($sformatf("rnd%0d mWe", k), 32'(mem.mWe), 32'(st));
                    if (st) chk($sformatf("rnd%0d mWData", k), mem.mWData, m_wd(ctl, din));
                end
                if (c == wbc) begin
                    if (!skipv) chk($sformatf("rnd%0d wbOut", k), wbOut, ev);
                    chk($sformatf("rnd%0d wbRd", k), 32'(wbRd), 32'(rdi));
                end
                if (c == excc) chk($sformatf("rnd%0d excCause", k), 32'(excCause), 32'(ecause));
                step();
            end
            mem.mGnt = 1'b0; mem.mRValid = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        mem.mGnt = 1'b0; mem.mRValid = 1'b0; mem.mRData = 32'h0;
        //          wc     rd    wr    ctl     pc          alu           din           rdata         ex    cause  be     wd            wbo
        vt[0]  = '{2'b00, 1'b0, 1'b0, 3'b000, 32'h104,    32'h0,        32'h0,        32'h0,        1'b0, 2'd0, 4'h0, 32'h0,        32'h104};
        vt[1]  = '{2'b01, 1'b0, 1'b0, 3'b000, 32'h0,      32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 2'd0, 4'h0, 32'h0,        32'hDEADBEEF};
        vt[2]  = '{2'b11, 1'b0, 1'b0, 3'b000, 32'h55,     32'h66,       32'h0,        32'h0,        1'b0, 2'd0, 4'h0, 32'h0,        32'h0};
        vt[3]  = '{2'b01, 1'b0, 1'b1, 3'b000, 32'h0,      32'h003,      32'h0000_00A5,32'h0,        1'b0, 2'd0, 4'h8, 32'hA5A5_A5A5,32'h003};
        vt[4]  = '{2'b00, 1'b0, 1'b1, 3'b001, 32'h200,    32'h002,      32'h1234_ABCD,32'h0,        1'b0, 2'd0, 4'hC, 32'hABCD_ABCD,32'h200};
        vt[5]  = '{2'b01, 1'b0, 1'b1, 3'b010, 32'h0,      32'hFFFF_F010,32'hCAFE_F00D,32'h0,        1'b0, 2'd0, 4'hF, 32'hCAFE_F00D,32'hFFFF_F010};
        vt[6]  = '{2'b10, 1'b1, 1'b0, 3'b000, 32'h0,      32'h001,      32'h0,        32'h0000_8000,1'b0, 2'd0, 4'h2, 32'h0,        32'hFFFF_FF80};
        vt[7]  = '{2'b10, 1'b1, 1'b0, 3'b100, 32'h0,      32'h002,      32'h0,        32'h00AB_0000,1'b0, 2'd0, 4'h4, 32'h0,        32'h0000_00AB};
        vt[8]  = '{2'b10, 1'b1, 1'b0, 3'b010, 32'h0,      32'h004,      32'h0,        32'h8765_4321,1'b0, 2'd0, 4'hF, 32'h0,        32'h8765_4321};
        vt[9]  = '{2'b10, 1'b1, 1'b0, 3'b001, 32'h0,      32'h000,      32'h0,        32'h0000_7FFF,1'b0, 2'd0, 4'h3, 32'h0,        32'h0000_7FFF};
        vt[10] = '{2'b10, 1'b1, 1'b0, 3'b011, 32'h0,      32'h000,      32'h0,        32'h0,        1'b1, 2'd0, 4'h0, 32'h0,        32'h0};
        vt[11] = '{2'b00, 1'b0, 1'b1, 3'b100, 32'h0,      32'h000,      32'h0,        32'h0,        1'b1, 2'd0, 4'h0, 32'h0,        32'h0};
        vt[12] = '{2'b00, 1'b0, 1'b1, 3'b010, 32'h0,      32'h001,      32'h0,        32'h0,        1'b1, 2'd2, 4'h0, 32'h0,        32'h0};
        vt[13] = '{2'b10, 1'b1, 1'b0, 3'b010, 32'h0,      32'h006,      32'h0,        32'h0,        1'b1, 2'd1, 4'h0, 32'h0,        32'h0};
        vt[14] = '{2'b10, 1'b1, 1'b0, 3'b110, 32'h0,      32'h000,      32'h0,        32'h0,        1'b1, 2'd0, 4'h0, 32'h0,        32'h0};
        vt[15] = '{2'b01, 1'b1, 1'b1, 3'b010, 32'h0,      32'h008,      32'h1122_3344,32'h0,        1'b0, 2'd0, 4'hF, 32'h1122_3344,32'h008};
        vt[16] = '{2'b10, 1'b1, 1'b0, 3'b101, 32'h0,      32'h002,      32'h0,        32'h8001_0000,1'b0, 2'd0, 4'hC, 32'h0,        32'h0000_8001};
        vt[17] = '{2'b10, 1'b1, 1'b0, 3'b001, 32'h0,      32'h003,      32'h0,        32'h0,        1'b1, 2'd1, 4'h0, 32'h0,        32'h0};

        step(); step();
        chk("rst inReady", 32'(inReady), 32'd1);
        chk("rst mReq", 32'(mem.mReq), 32'd0);
        chk("rst mBe", 32'(mem.mBe), 32'd0);
        chk("rst mWData", mem.mWData, 32'h0);
        chk("rst wbValid", 32'(wbValid), 32'd0);
        chk("rst exc", 32'(exc), 32'd0);
        chk("rst wbOut", wbOut, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            v = vt[i];
            chk($sformatf("vec%0d inReady", i), 32'(inReady), 32'd1);
            drive(v.wc, v.rd, v.wr, v.ctl, v.pc, v.alu, v.din, 5'(i + 1));
            step(); inValid = 1'b0;
            if (v.ex) begin
                chk($sformatf("vec%0d exc", i), 32'(exc), 32'd1);
                chk($sformatf("vec%0d excCause", i), 32'(excCause), 32'(v.cause));
                chk($sformatf("vec%0d mReq", i), 32'(mem.mReq), 32'd0);
                chk($sformatf("vec%0d wbValid", i), 32'(wbValid), 32'd0);
                step();
                chk($sformatf("vec%0d exc drop", i), 32'(exc), 32'd0);
                chk($sformatf("vec%0d wbValid c2", i), 32'(wbValid), 32'd0);
            end else if (v.rd || v.wr) begin
                chk($sformatf("vec%0d mReq", i), 32'(mem.mReq), 32'd1);
                chk($sformatf("vec%0d mBe", i), 32'(mem.mBe), 32'(v.be));
                chk($sformatf("vec%0d mAddr", i), 32'(mem.mAddr), 32'(v.alu[AW-1:2]));
                chk($sformatf("vec%0d mWe", i), 32'(mem.mWe), 32'(v.wr));
                if (v.wr) chk($sformatf("vec%0d mWData", i), mem.mWData, v.wd);
                chk($sformatf("vec%0d wbValid c1", i), 32'(wbValid), 32'd0);
                mem.mGnt = 1'b1; mem.mRValid = 1'b1; mem.mRData = v.rdata;
                step(); mem.mGnt = 1'b0; mem.mRValid = 1'b0;
                chk($sformatf("vec%0d wbValid", i), 32'(wbValid), 32'd1);
                chk($sformatf("vec%0d wbOut", i), wbOut, v.wbo);
                chk($sformatf("vec%0d wbRd", i), 32'(wbRd), 32'(i + 1));
                chk($sformatf("vec%0d mReq drop", i), 32'(mem.mReq), 32'd0);
                step();
                chk($sformatf("vec%0d wbValid drop", i), 32'(wbValid), 32'd0);
            end else begin
                chk($sformatf("vec%0d wbValid", i), 32'(wbValid), 32'd1);
                chk($sformatf("vec%0d wbOut", i), wbOut, v.wbo);
                chk($sformatf("vec%0d wbRd", i), 32'(wbRd), 32'(i + 1));
                chk($sformatf("vec%0d inReady resp", i), 32'(inReady), 32'd0);
                inValid = 1'b1;
                #1 chk($sformatf("vec%0d stall", i), 32'(stall), 32'd1);
                inValid = 1'b0;
                step();
                chk($sformatf("vec%0d wbValid drop", i), 32'(wbValid), 32'd0);
            end
        end

        load_latency(3'b001, 32'hFFFF_8001);
        load_latency(3'b101, 32'h0000_8001);

        // No grant ever: the request must give up after T cycles.
        drive(2'b10, 1'b1, 1'b0, 3'b010, 32'h0, 32'h000, 32'h0, 5'd3);
        step(); inValid = 1'b0;
        for (int c = 1; c <= T; c++) begin
            chk($sformatf("tmo mReq c%0d", c), 32'(mem.mReq), 32'd1);
            chk($sformatf("tmo exc c%0d", c), 32'(exc), 32'd0);
            step();
        end
        chk("tmo mReq drop", 32'(mem.mReq), 32'd0);
        chk("tmo exc", 32'(exc), 32'd1);
        chk("tmo excCause", 32'(excCause), 32'd3);
        chk("tmo wbValid", 32'(wbValid), 32'd0);
        step();
        chk("tmo exc drop", 32'(exc), 32'd0);
        chk("tmo inReady", 32'(inReady), 32'd1);

        // Reset while waiting for read data, then a stale response.
        drive(2'b10, 1'b1, 1'b0, 3'b010, 32'h0, 32'h010, 32'h0, 5'd9);
        step(); inValid = 1'b0; mem.mGnt = 1'b1;
        step(); mem.mGnt = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        chk("midrst mReq", 32'(mem.mReq), 32'd0);
        chk("midrst mBe", 32'(mem.mBe), 32'd0);
        chk("midrst mAddr", 32'(mem.mAddr), 32'd0);
        chk("midrst wbOut", wbOut, 32'h0);
        chk("midrst wbRd", 32'(wbRd), 32'd0);
        chk("midrst inReady", 32'(inReady), 32'd1);
        mem.mRValid = 1'b1; mem.mRData = 32'h1234_5678;
        step(); mem.mRValid = 1'b0;
        chk("midrst stale wbValid", 32'(wbValid), 32'd0);
        drive(2'b00, 1'b0, 1'b0, 3'b000, 32'h0000_0ABC, 32'h0, 32'h0, 5'd4);
        step(); inValid = 1'b0;
        chk("postrst wbValid", 32'(wbValid), 32'd1);
        chk("postrst wbOut", wbOut, 32'h0000_0ABC);
        step();

        run_random(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_wb.md
# lsu_wb

Parametrised load/store and writeback stage for the pipelined RV32 core, replacing the fixed 12-bit single-cycle data-memory-plus-writeback stage. It accepts one instruction at a time from EX over a valid/ready handshake and drives an external variable-latency data memory over a request/grant/response-valid interface. It performs byte-lane steering, sign/zero extension, misalignment and illegal-size detection, and transaction timeout. It selects the writeback value and presents it with a single-cycle `wbValid` strobe.

## Interface
- `ADDR_W`, default 12: byte-address bits used; `mAddr` = `aluOut[ADDR_W-1:2]`; upper `aluOut` bits ignored.
- `TIMEOUT`, default 15: maximum cycles spent in REQ+WAIT before abort; must be ≥ 1.
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `inValid` in 1: EX presents an instruction.
- `inReady` out 1: stage can accept an instruction; high iff state = IDLE.
- `wbCtrl` in 2: writeback select. 00 = `pcN`, 01 = `aluOut`, 10 = load data, 11 = zero.
- `memRD`, `memWR` in 1 each: load / store; both high is treated as a store.
- `memCtrl` in 3: funct3 size code. 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are valid for loads only.
- `pcN`, `aluOut`, `dataIn` in 32: PC+4, address/ALU result, store data.
- `rdIn` in 5: destination register.
- `mReq` out 1: memory request.
- `mWe` out 1: write enable.
- `mAddr` out ADDR_W-2: word address.
- `mBe` out 4: byte enables.
- `mWData` out 32: lane-steered store data.
- `mGnt` in 1: memory accepts the request this cycle.
- `mRValid` in 1: read data valid.
- `mRData` in 32: read data.
- `wbValid` out 1: one-cycle strobe marking the writeback result.
- `wbRd` out 5: destination register, registered.
- `wbOut` out 32: writeback value, registered.
- `stall` out 1: `inValid && !inReady`.
- `exc` out 1: one-cycle exception strobe.
- `excCause` out 2: 00 illegal `memCtrl`, 01 load misaligned, 10 store misaligned, 11 timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- Accept: `inValid && inReady && !rst`. On accept, capture all inputs into the stage register.
- Non-memory op (`memRD` = `memWR` = 0): IDLE → RESP.
- Memory op, checks done on the captured values at accept:
  - Illegal `memCtrl` → exc, cause 00. Illegal codes are 011, 11x, and 100/101 on a store.
  - H access with `addr[0]` set, or W access with `addr[1:0]` ≠ 0 → exc, cause 01 for a load or 10 for a store.
  - On any exception: no `mReq`, no `wbValid`, `exc` pulses in the next cycle, return to IDLE.
- Memory op, legal: IDLE → REQ. `mReq` and `mWe`/`mAddr`/`mBe`/`mWData` are held stable until `mGnt`.
  - Store with `mGnt` → RESP.
  - Load with `mGnt && mRValid` in the same cycle → RESP.
  - Load with `mGnt` only → WAIT. WAIT → RESP on `mRValid`.
- RESP: `wbValid` = 1 for exactly one cycle, then IDLE. `inReady` is low in RESP, so back-to-back throughput is one instruction per 2 cycles minimum.
- Byte lanes (`off = addr[1:0]`):
  - B: `mBe` = 0001 << off; `mWData` = `dataIn[7:0]` replicated ×4.
  - H: `mBe` = 0011 << (2·`addr[1]`); `mWData` = `dataIn[15:0]` replicated ×2.
  - W: `mBe` = 1111; `mWData` = `dataIn`.
  - Loads drive `mBe` the same way; `mWe` = 0.
- Load extension: select byte `off` or half `addr[1]` from `mRData`. B/H sign-extend; BU/HU zero-extend; W passes through. The result is registered when `mRValid` is seen.
- Timeout: a counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches `TIMEOUT` without completion: drop `mReq`, `exc` = 1 with cause 11, return to IDLE, no `wbValid`.
- `mRValid` and `mGnt` are ignored in IDLE and RESP.

## Timing
- Reset values, applied at the first edge with `rst` high: state IDLE; `mReq`, `mWe`, `wbValid`, `exc` = 0; `mBe` = 0; `mAddr`, `mWData`, `wbOut`, `wbRd`, `excCause` = 0; counter = 0. No accept occurs while `rst` is high.
- Reset mid-transaction aborts at that edge and discards a later `mRValid`.
- Latency from the accept edge at cycle 0:
  - Non-memory op: `wbValid` at cycle 1.
  - Exception: `exc` at cycle 1.
  - Zero-wait store/load (`mGnt`, plus `mRValid` for loads, in cycle 1): `wbValid` at cycle 2.
  - Load whose `mRValid` arrives in cycle j: `wbValid` at cycle j+1.
- `mReq` is a registered output; memory outputs change only on the accept edge.
- `wbOut`, `wbRd` hold their value until the next RESP.

## Test plan
- Non-memory op: `wbCtrl` = 00, `pcN` = 0x104 → `wbValid` and `wbOut` = 0x104 one cycle after accept; `inReady` = 0 during RESP.
- Store: SB, `aluOut` = 0x003, `dataIn` = 0x000000A5, `mGnt` in cycle 1 → `mBe` = 1000, `mWData` = 0xA5A5A5A5, `wbValid` at cycle 2.
- Load: LH at 0x002, `mRData` = 0x8001_0000, `mRValid` 3 cycles after `mGnt` → `wbOut` = 0xFFFF8001. Repeat with LHU → `wbOut` = 0x00008001.
- Misaligned load: LW at 0x006 → `exc` = 1 with `excCause` = 01 at cycle 1; `mReq` never asserts; no `wbValid`.
- Timeout: `TIMEOUT` = 4, `mGnt` held low → `mReq` high for 4 cycles, then `exc` with cause 11 and return to IDLE.
- Reset mid-transaction: `rst` asserted in WAIT, then a late `mRValid` → outputs at reset values, no `wbValid`; the next instruction is accepted normally.
